cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
//   Control unit of the EC-1 8-bit accumulator CPU; the consumer of the instruction register's outputs.
//   Takes opcode IR[7:5] plus datapath status and steps FETCH -> DECODE -> EXECUTE.
//   Drives every datapath control line, including ir_load back to the IR, and PC/memory/accumulator controls.
//   State register updates on posedge clk. The IR captures on negedge, so the opcode is stable by the next posedge.
// PARAMETERS
//   OP_W      3   opcode width (IR[7:5])
//   ST_W      4   state encoding width, exported on state_o
// PORTS
//   clk        in   1     system clock, state register on rising edge
//   reset      in   1     asynchronous, active-high; forces START
//   opcode     in   3     IR[7:5] from instruction register
//   aeq0       in   1     accumulator == 0
//   apos       in   1     accumulator > 0 (signed, nonzero, MSB=0)
//   enter      in   1     debounced user Enter key, level
//   ir_load    out  1     load IR from memory output
//   pc_load    out  1     load PC
//   jmp_mux    out  1     PC source: 0 = PC+1, 1 = IR[3:0]
//   mem_inst   out  1     memory address: 0 = PC, 1 = IR[3:0]
//   mem_wr     out  1     memory write strobe (A -> M[IR[3:0]])
//   a_sel      out  2     A source: 00 = ALU, 01 = input port, 10 = memory, 11 = zero
//   a_load     out  1     load accumulator
//   alu_sub    out  1     ALU op: 0 = add, 1 = subtract
//   halt       out  1     CPU halted indicator
//   state_o    out  4     current state (debug / LED)
// BEHAVIOUR
//   Reset: state = START, enter_q = 0.
//   During reset: all control outputs 0, a_sel = 00, state_o = START code.
//   Outputs are Moore, decoded from state only, except pc_load in JZ/JPOS and a_load in INPUT.
//   Opcodes:
//     000 LOAD   A <= M[aaaa]
//     001 STORE  M[aaaa] <= A
//     010 ADD    A <= A + M[aaaa]
//     011 SUB    A <= A - M[aaaa]
//     100 INPUT  A <= input port
//     101 JZ     if A == 0, PC <= aaaa
//     110 JPOS   if A > 0, PC <= aaaa
//     111 HALT
//   State actions (unlisted outputs 0):
//     START  : none                                           -> FETCH
//     FETCH  : ir_load=1, pc_load=1, jmp_mux=0, mem_inst=0     -> DECODE
//     DECODE : mem_inst=1 (pre-address operand)                -> exec state chosen by opcode
//     LOAD   : mem_inst=1, a_sel=10, a_load=1                  -> FETCH
//     STORE  : mem_inst=1, mem_wr=1                            -> FETCH
//     ADD    : mem_inst=1, a_sel=00, alu_sub=0, a_load=1       -> FETCH
//     SUB    : mem_inst=1, a_sel=00, alu_sub=1, a_load=1       -> FETCH
//     INPUT  : a_sel=01, a_load=press;
//              press = enter & ~enter_q (rising edge only);
//              stay until press, then -> FETCH
//     JZ     : jmp_mux=1, pc_load=aeq0                         -> FETCH
//     JPOS   : jmp_mux=1, pc_load=apos                         -> FETCH
//     HALT   : halt=1; stays until reset
//   Latency: every instruction takes 3 cycles (FETCH, DECODE, EXEC), except INPUT (>= 3, waits for press).
//   Enter: held level counts as one press; a second INPUT needs release then re-press.
//     enter_q is updated every cycle, in all states.
//   Reset mid-instruction (e.g. during STORE): mem_wr drops immediately; resumes at START.
//   Unreachable state codes -> START on next clock; outputs 0 while in them.
//   mem_wr is asserted for exactly one cycle per STORE.
// STRUCTURE
//   Package cpu_ctrl_pkg:
//     OP_LOAD..OP_HALT opcode constants
//     ST_* state encodings (ST_W bits)
//     ASEL_ALU / ASEL_IN / ASEL_MEM / ASEL_ZERO
//   Sub-module enter_edge: enter_q register + rising-edge press pulse, async reset.
//   Top: state register, next-state logic, output decode.
// TESTING
//   1. Reset then release -> START for 1 cycle, FETCH with ir_load=pc_load=1, then DECODE.
//   2. opcode=000 -> after DECODE: a_sel=10, a_load=1 for one cycle, then back to FETCH.
//      Repeat for 010 (alu_sub=0) and 011 (alu_sub=1).
//   3. opcode=001 -> mem_wr=1, mem_inst=1 for exactly one cycle; reset asserted mid-STORE -> mem_wr=0 same cycle.
//   4. opcode=101: aeq0=1 -> pc_load=1, jmp_mux=1; aeq0=0 -> pc_load=0.
//      opcode=110 with apos=1 and apos=0 -> same pattern.
//   5. opcode=100, enter held 1 from before INPUT -> no load until release then re-press; a_load pulses once.
//   6. opcode=111 -> halt=1 for 20+ cycles with opcode changing; reset -> halt=0, START.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the EC-1 control unit: opcodes, state codes, A-source selects.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
//
// Contents:
//   OPCODE_W / STATE_W   widths of the opcode field and the state register
//   OP_*                 opcode values of IR[7:5]
//   state_e              FSM state encoding, also exported on state_o
//   ASEL_*               accumulator source select values
//   exec_state()         opcode -> execute state mapping used by DECODE
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 3;
    localparam int STATE_W  = 4;

    // Instruction opcodes, IR[7:5]
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_STORE = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_INPUT = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_JZ    = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_JPOS  = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 3'b111;

    // State codes. Codes 11..15 are unused and recover to START.
    typedef enum logic [STATE_W-1:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd3,
        ST_STORE  = 4'd4,
        ST_ADD    = 4'd5,
        ST_SUB    = 4'd6,
        ST_INPUT  = 4'd7,
        ST_JZ     = 4'd8,
        ST_JPOS   = 4'd9,
        ST_HALT   = 4'd10
    } state_e;

    // Accumulator source select
    localparam logic [1:0] ASEL_ALU  = 2'b00;
    localparam logic [1:0] ASEL_IN   = 2'b01;
    localparam logic [1:0] ASEL_MEM  = 2'b10;
    localparam logic [1:0] ASEL_ZERO = 2'b11;

    // Execute state that DECODE hands over to for a given opcode.
    function automatic state_e exec_state(input logic [OPCODE_W-1:0] op);
        state_e st;
        case (op)
            OP_LOAD:  st = ST_LOAD;
            OP_STORE: st = ST_STORE;
            OP_ADD:   st = ST_ADD;
            OP_SUB:   st = ST_SUB;
            OP_INPUT: st = ST_INPUT;
            OP_JZ:    st = ST_JZ;
            OP_JPOS:  st = ST_JPOS;
            default:  st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_enter_edge.sv
// Rising-edge detector for the debounced Enter key: one press pulse per key-down.
// Latency: press is combinational from enter, qualified by last cycle's level.
// Backpressure: none; enter_q tracks the key every cycle regardless of CPU state.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high; clears enter_q
//   enter  in   debounced Enter level
//   press  out  high while enter is 1 and was 0 on the previous clock
module enter_edge (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic press
);

    logic enter_q;

    // Sampled unconditionally so a key held across instructions is already
    // "seen" when INPUT is entered and cannot count as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_q <= 1'b0;
        end else begin
            enter_q <= enter;
        end
    end

    assign press = enter & ~enter_q;

endmodule

// File: rtl/cpu_control_fsm.sv
// Control unit of the EC-1 accumulator CPU: FETCH -> DECODE -> EXECUTE sequencing.
// Latency: 3 cycles per instruction; INPUT holds in EXECUTE until an Enter press.
// Backpressure: only the Enter key stalls (INPUT); HALT parks until reset.
//
// Ports:
//   clk, reset            rising-edge clock; async active-high reset to START
//   opcode                IR[7:5], captured by the IR on negedge, stable at posedge
//   aeq0, apos            accumulator status (zero / strictly positive)
//   enter                 debounced Enter key level
//   ir_load, pc_load      IR and PC load strobes
//   jmp_mux               PC source: 0 = PC+1, 1 = IR[3:0]
//   mem_inst              memory address: 0 = PC, 1 = IR[3:0]
//   mem_wr                memory write strobe (A -> M[IR[3:0]])
//   a_sel, a_load         accumulator source select and load
//   alu_sub               ALU op: 0 = add, 1 = subtract
//   halt                  CPU halted indicator
//   state_o               current state code for debug LEDs
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W = 3,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            aeq0,
    input  logic            apos,
    input  logic            enter,
    output logic            ir_load,
    output logic            pc_load,
    output logic            jmp_mux,
    output logic            mem_inst,
    output logic            mem_wr,
    output logic [1:0]      a_sel,
    output logic            a_load,
    output logic            alu_sub,
    output logic            halt,
    output logic [ST_W-1:0] state_o
);

    state_e state;
    state_e next_state;
    logic   press;

    enter_edge u_enter_edge (
        .clk   (clk),
        .reset (reset),
        .enter (enter),
        .press (press)
    );

    // Next-state logic. DECODE samples the opcode the IR latched on the
    // preceding negedge; every other state ignores it.
    always_comb begin
        next_state = ST_START;
        case (state)
            ST_START:  next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = exec_state(OPCODE_W'(opcode));
            ST_LOAD,
            ST_STORE,
            ST_ADD,
            ST_SUB,
            ST_JZ,
            ST_JPOS:   next_state = ST_FETCH;
            ST_INPUT:  next_state = press ? ST_FETCH : ST_INPUT;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_START;
        endcase
    end

    // State register. The asynchronous reset forces START, and because the
    // outputs decode from this register, an in-flight strobe such as mem_wr
    // drops as soon as reset rises rather than at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // Output decode. Moore from the state, except pc_load in the conditional
    // jumps (follows live accumulator status) and a_load in INPUT (follows the
    // press pulse so the port value is captured exactly once).
    always_comb begin
        ir_load  = 1'b0;
        pc_load  = 1'b0;
        jmp_mux  = 1'b0;
        mem_inst = 1'b0;
        mem_wr   = 1'b0;
        a_sel    = ASEL_ALU;
        a_load   = 1'b0;
        alu_sub  = 1'b0;
        halt     = 1'b0;
        case (state)
            ST_FETCH: begin
                // Read M[PC] into IR and advance PC to PC+1 together.
                ir_load = 1'b1;
                pc_load = 1'b1;
            end
            ST_DECODE: begin
                // Present the operand address early so memory data is
                // settled when the execute state consumes it.
                mem_inst = 1'b1;
            end
            ST_LOAD: begin
                mem_inst = 1'b1;
                a_sel    = ASEL_MEM;
                a_load   = 1'b1;
            end
            ST_STORE: begin
                mem_inst = 1'b1;
                mem_wr   = 1'b1;
            end
            ST_ADD: begin
                mem_inst = 1'b1;
                a_sel    = ASEL_ALU;
                a_load   = 1'b1;
            end
            ST_SUB: begin
                mem_inst = 1'b1;
                a_sel    = ASEL_ALU;
                alu_sub  = 1'b1;
                a_load   = 1'b1;
            end
            ST_INPUT: begin
                a_sel  = ASEL_IN;
                a_load = press;
            end
            ST_JZ: begin
                jmp_mux = 1'b1;
                pc_load = aeq0;
            end
            ST_JPOS: begin
                jmp_mux = 1'b1;
                pc_load = apos;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                // START and unused codes: everything stays deasserted.
            end
        endcase
    end

    assign state_o = ST_W'(state);

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       aeq0, apos, enter;
    logic       ir_load, pc_load, jmp_mux, mem_inst, mem_wr;
    logic [1:0] a_sel;
    logic       a_load, alu_sub, halt;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_errors = 0;
    // Reference view of the Enter level seen at the last rising edge.
    logic enter_prev = 1'b0;

    cpu_control_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .aeq0     (aeq0),
        .apos     (apos),
        .enter    (enter),
        .ir_load  (ir_load),
        .pc_load  (pc_load),
        .jmp_mux  (jmp_mux),
        .mem_inst (mem_inst),
        .mem_wr   (mem_wr),
        .a_sel    (a_sel),
        .a_load   (a_load),
        .alu_sub  (alu_sub),
        .halt     (halt),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // Control word layout: ir pc jmp mi wr a_sel[1:0] a_load sub halt state[3:0]
    function automatic logic [13:0] cw(input logic ir, pc, jm, mi, wr,
                                       input logic [1:0] as,
                                       input logic al, su, h,
                                       input logic [3:0] st);
        return {ir, pc, jm, mi, wr, as, al, su, h, st};
    endfunction

    localparam logic [13:0] V_START  = {10'b0, 4'd0};
    localparam logic [13:0] V_FETCH  = {10'b11_0000_0000, 4'd1};
    localparam logic [13:0] V_DECODE = {10'b00_0100_0000, 4'd2};

    // Expected execute-cycle control word, derived from what each
    // instruction does rather than from a state table.
    function automatic logic [13:0] exp_exec(input logic [2:0] op, input logic z, p, pr);
        logic       mem_operand, wr, ld, jmp, pcl, sub, h;
        logic [1:0] src;
        logic [3:0] code;
        mem_operand = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
        wr   = (op == OP_STORE);
        ld   = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || ((op == OP_INPUT) && pr);
        src  = (op == OP_LOAD) ? ASEL_MEM : (op == OP_INPUT) ? ASEL_IN : ASEL_ALU;
        sub  = (op == OP_SUB);
        jmp  = (op == OP_JZ) || (op == OP_JPOS);
        pcl  = ((op == OP_JZ) && z) || ((op == OP_JPOS) && p);
        h    = (op == OP_HALT);
        code = 4'(op) + 4'd3;  // execute states follow DECODE in opcode order
        return cw(1'b0, pcl, jmp, mem_operand, wr, src, ld, sub, h, code);
    endfunction

    task automatic chk(input logic [13:0] exp, input string tag);
        logic [13:0] obs;
        #1;
        obs = {ir_load, pc_load, jmp_mux, mem_inst, mem_wr, a_sel, a_load, alu_sub, halt, state_o};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        enter_prev = reset ? 1'b0 : enter;
        @(negedge clk);
    endtask

    // Runs one instruction starting in FETCH, checking every cycle.
    task automatic run_instr(input logic [2:0] op, input logic z, p,
                             input bit hold_enter, input bit rst_mid, input string tag);
        logic pr;
        logic done;
        opcode = 3'($urandom);
        enter  = hold_enter ? 1'b1 : 1'($urandom);
        aeq0   = 1'($urandom);
        apos   = 1'($urandom);
        chk(V_FETCH, {tag, "/fetch"});
        tick();
        opcode = op;
        enter  = hold_enter ? 1'b1 : 1'($urandom);
        chk(V_DECODE, {tag, "/decode"});
        tick();
        opcode = 3'($urandom);
        aeq0   = z;
        apos   = p;
        if (op == OP_INPUT) begin
            done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (hold_enter) enter = (k != 3);
                else            enter = (k < 8) ? 1'($urandom) : 1'(k % 2);
                pr = enter && !enter_prev;
                chk(exp_exec(op, z, p, pr), {tag, "/input"});
                tick();
                if (pr) begin
                    done = 1'b1;
                    break;
                end
            end
            n_checks++;
            assert (done === 1'b1) else begin
                n_errors++;
                $error("FAIL %s/input_done observed %b expected 1", tag, done);
            end
        end else if (op == OP_HALT) begin
            for (int k = 0; k < 25; k++) begin
                opcode = 3'($urandom);
                enter  = 1'($urandom);
                chk(exp_exec(op, z, p, 1'b0), {tag, "/halt"});
                tick();
            end
        end else begin
            chk(exp_exec(op, z, p, 1'b0), {tag, "/exec"});
            if (rst_mid) begin
                #2 reset = 1'b1;
                chk(V_START, {tag, "/mid_reset"});
                tick();
                reset = 1'b0;
                chk(V_START, {tag, "/restart"});
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        opcode = 3'd0;
        aeq0   = 1'b0;
        apos   = 1'b0;
        enter  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(V_START, "in_reset");
        reset = 1'b0;
        chk(V_START, "start");
        tick();

        // Directed: each instruction, both branch outcomes.
        run_instr(OP_LOAD,  1'b0, 1'b0, 1'b0, 1'b0, "load");
        run_instr(OP_ADD,   1'b0, 1'b0, 1'b0, 1'b0, "add");
        run_instr(OP_SUB,   1'b0, 1'b0, 1'b0, 1'b0, "sub");
        run_instr(OP_STORE, 1'b0, 1'b0, 1'b0, 1'b0, "store");
        run_instr(OP_JZ,    1'b1, 1'b0, 1'b0, 1'b0, "jz_taken");
        run_instr(OP_JZ,    1'b0, 1'b1, 1'b0, 1'b0, "jz_not");
        run_instr(OP_JPOS,  1'b0, 1'b1, 1'b0, 1'b0, "jpos_taken");
        run_instr(OP_JPOS,  1'b1, 1'b0, 1'b0, 1'b0, "jpos_not");
        // Enter held from before INPUT: only release-then-press loads.
        run_instr(OP_INPUT, 1'b0, 1'b0, 1'b1, 1'b0, "input_hold1");
        run_instr(OP_INPUT, 1'b0, 1'b0, 1'b1, 1'b0, "input_hold2");

        // Randomized instruction stream (no HALT).
        for (int i = 0; i < 40; i++) begin
            run_instr(3'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 1'b0, 1'b0, "rand");
        end

        // Reset in the middle of STORE, then resume from START.
        run_instr(OP_STORE, 1'b0, 1'b0, 1'b0, 1'b1, "store_rst");
        run_instr(OP_ADD,   1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

        // HALT parks regardless of opcode, until reset.
        run_instr(OP_HALT,  1'b0, 1'b0, 1'b0, 1'b0, "halt");
        reset = 1'b1;
        chk(V_START, "halt_reset");
        tick();
        reset = 1'b0;
        chk(V_START, "halt_restart");
        tick();
        chk(V_FETCH, "halt_refetch");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
